// File: rtl/c64_bus_pkg.sv
// Shared encodings for the C64 bus arbiter: FSM states, bus owner codes and
// the default BA-to-steal warning distance.
package c64_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WARN  = 2'd1,
      ST_STEAL = 2'd2,
      ST_DMA   = 2'd3
   } arb_state_e;

   localparam logic [1:0] SEL_CPU = 2'd0;
   localparam logic [1:0] SEL_VIC = 2'd1;
   localparam logic [1:0] SEL_DMA = 2'd2;

   localparam int WARN_CYCLES_DEF = 3;

endpackage

// File: rtl/bus_arbiter.sv
// C64-style bus arbiter: VIC-II cycle stealing behind a BA warning window,
// plus expansion-port DMA when BUS_ARBITER_DMA_EN is defined (ignored otherwise).
module bus_arbiter
   import c64_bus_pkg::*;
#(
   parameter int WARN_CYCLES = WARN_CYCLES_DEF,
   parameter int CNT_W       = 16
) (
   input  logic             dot_clk,
   input  logic             res_n,
   input  logic             phi_en,
   input  logic             vic_req,
   input  logic             dma_req,
   input  logic             cnt_clr,
   output logic             ba,
   output logic             aec,
   output logic             rdy,
   output logic             dma_gnt,
   output logic [1:0]       bus_sel,
   output logic [CNT_W-1:0] steal_cnt
);

   localparam int            WC_W      = (WARN_CYCLES > 1) ? $clog2(WARN_CYCLES) : 1;
   localparam logic [WC_W-1:0] WARN_LOAD = WC_W'(WARN_CYCLES - 1);

   // Handshake: vic_req and dma_req are level requests sampled only on a
   // phi_en edge; ownership is reported through ba/aec/dma_gnt/bus_sel on
   // that same edge and holds until a later phi_en edge changes it.
   arb_state_e       state_q, state_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic             ba_q, ba_d;
   logic             aec_q, aec_d;
   logic             rdy_q, rdy_d;
   logic             gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_idle;

`ifndef BUS_ARBITER_DMA_EN
   logic unused_dma_req;
   assign unused_dma_req = dma_req;
`endif

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      ba_d    = ba_q;
      aec_d   = aec_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      to_idle = 1'b0;

      if (phi_en) begin
         case (state_q)
            ST_IDLE: begin
               if (vic_req) begin
                  state_d = ST_WARN;
                  wcnt_d  = WARN_LOAD;
                  ba_d    = 1'b1;
               end
`ifdef BUS_ARBITER_DMA_EN
               else if (dma_req) begin
                  state_d = ST_DMA;
                  gnt_d   = 1'b1;
                  sel_d   = SEL_DMA;
               end
`endif
            end
            // Warning window: CPU/DMA keep the bus while BA gives the CPU time to stop.
            ST_WARN: begin
               if (!vic_req) begin
                  to_idle = 1'b1;
               end else if (wcnt_q == '0) begin
                  state_d = ST_STEAL;
                  aec_d   = 1'b0;
                  gnt_d   = 1'b0;
                  sel_d   = SEL_VIC;
               end else begin
                  wcnt_d = wcnt_q - WC_W'(1);
               end
            end
            ST_STEAL: begin
               if (!vic_req) begin
                  to_idle = 1'b1;
               end
            end
`ifdef BUS_ARBITER_DMA_EN
            ST_DMA: begin
               if (vic_req) begin
                  state_d = ST_WARN;
                  wcnt_d  = WARN_LOAD;
                  ba_d    = 1'b1;
               end else if (!dma_req) begin
                  to_idle = 1'b1;
               end
            end
`endif
            default: begin
               to_idle = 1'b1;
            end
         endcase
      end

      if (to_idle) begin
         state_d = ST_IDLE;
         wcnt_d  = '0;
         ba_d    = 1'b0;
         aec_d   = 1'b1;
         gnt_d   = 1'b0;
         sel_d   = SEL_CPU;
      end

      rdy_d = !ba_d && !gnt_d;
   end

   // Clear wins over counting; counting stops at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (phi_en && (state_q == ST_STEAL) && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge dot_clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         ba_q    <= 1'b0;
         aec_q   <= 1'b1;
         rdy_q   <= 1'b1;
         gnt_q   <= 1'b0;
         sel_q   <= SEL_CPU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ba_q    <= ba_d;
         aec_q   <= aec_d;
         rdy_q   <= rdy_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ba        = ba_q;
   assign aec       = aec_q;
   assign rdy       = rdy_q;
   assign dma_gnt   = gnt_q;
   assign bus_sel   = sel_q;
   assign steal_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: reference model tracks how long vic_req has been held
// and who owned the bus before, and predicts outputs after every phi_en edge.
module tb_bus_arbiter;

   localparam int WARN = 3;
   localparam int CW   = 16;
   localparam int VW   = CW + 6;
`ifdef BUS_ARBITER_DMA_EN
   localparam bit DMA_EN = 1'b1;
`else
   localparam bit DMA_EN = 1'b0;
`endif

   logic          dot_clk = 1'b0;
   logic          res_n;
   logic          phi_en;
   logic          vic_req;
   logic          dma_req;
   logic          cnt_clr;
   logic          ba;
   logic          aec;
   logic          rdy;
   logic          dma_gnt;
   logic [1:0]    bus_sel;
   logic [CW-1:0] steal_cnt;
   logic [VW-1:0] obs;

   int checks = 0;
   int errors = 0;
   bit fast   = 1'b0;

   // model: consecutive phi cycles with vic_req high, DMA ownership, counter
   int            m_run;
   bit            m_gnt;
   bit            m_warn_dma;
   logic [CW-1:0] m_cnt;
   logic [VW-1:0] exp_q[$];

   localparam logic [VW-1:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, {CW{1'b0}}};

   bus_arbiter #(.WARN_CYCLES(WARN), .CNT_W(CW)) dut (
      .dot_clk   (dot_clk),
      .res_n     (res_n),
      .phi_en    (phi_en),
      .vic_req   (vic_req),
      .dma_req   (dma_req),
      .cnt_clr   (cnt_clr),
      .ba        (ba),
      .aec       (aec),
      .rdy       (rdy),
      .dma_gnt   (dma_gnt),
      .bus_sel   (bus_sel),
      .steal_cnt (steal_cnt)
   );

   assign obs = {ba, aec, rdy, dma_gnt, bus_sel, steal_cnt};

   always #5 dot_clk = ~dot_clk;

   task automatic model_reset();
      m_run      = 0;
      m_gnt      = 1'b0;
      m_warn_dma = 1'b0;
      m_cnt      = '0;
   endtask

   task automatic model_phi(input bit v, input bit d, input bit c);
      int prev;
      prev  = m_run;
      m_run = v ? ((m_run > WARN) ? WARN + 1 : m_run + 1) : 0;
      if (c) m_cnt = '0;
      else if (prev > WARN && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (m_run == 1) m_warn_dma = m_gnt;
      m_gnt = DMA_EN && ((m_run == 0 && prev == 0 && d) ||
                         (m_run >= 1 && m_run <= WARN && m_warn_dma));
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic       e_ba, e_aec, e_gnt;
      logic [1:0] e_sel;
      e_ba  = (m_run >= 1);
      e_aec = (m_run <= WARN);
      e_gnt = m_gnt;
      e_sel = (m_run > WARN) ? 2'd1 : (m_gnt ? 2'd2 : 2'd0);
      return {e_ba, e_aec, (!e_ba && !e_gnt), e_gnt, e_sel, m_cnt};
   endfunction

   // One phi2 cycle: a few idle dot clocks, then one with phi_en high.
   task automatic phi_step(input bit v, input bit d, input bit c);
      int gap;
      gap = fast ? 0 : $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
         @(negedge dot_clk);
         phi_en = 1'b0; cnt_clr = 1'b0; vic_req = v; dma_req = d;
      end
      @(negedge dot_clk);
      phi_en = 1'b1; cnt_clr = c; vic_req = v; dma_req = d;
      @(posedge dot_clk);
      #1;
      phi_en  = 1'b0;
      cnt_clr = 1'b0;
      model_phi(v, d, c);
      exp_q.push_back(exp_vec());
   endtask

   task automatic test_reset();
      logic [VW-1:0] e;
      res_n = 1'b0; phi_en = 1'b1; vic_req = 1'b1; dma_req = 1'b1; cnt_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge dot_clk);
      #1;
      checks++;
      if (obs !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_hold got %h exp %h", obs, RESET_VEC);
      end
      @(negedge dot_clk);
      phi_en = 1'b0; dma_req = 1'b0; res_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge dot_clk);
         #1;
         checks++;
         if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_release_no_phi cyc=%0d got %h exp %h", i, obs, RESET_VEC);
         end
      end
      phi_step(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || ba !== 1'b1) begin
         errors++;
         $display("FAIL first_phi_after_reset got %h exp %h", obs, e);
      end
      phi_step(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_abort got %h exp %h", obs, e);
      end
   endtask

   task automatic test_long_steal();
      logic [VW-1:0] e;
      int n_warn = 0;
      int n_steal = 0;
      phi_step(1'b0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 43; i++) begin
         phi_step(1'b1, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL long_steal step=%0d got %h exp %h", i, obs, e);
         end
         if (ba === 1'b1 && aec === 1'b1) n_warn++;
         if (aec === 1'b0) n_steal++;
      end
      phi_step(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (n_warn != 3 || n_steal != 40) begin
         errors++;
         $display("FAIL long_steal_split got warn=%0d steal=%0d exp warn=3 steal=40", n_warn, n_steal);
      end
      checks++;
      if (steal_cnt !== 16'd40 || rdy !== 1'b1 || aec !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL long_steal_end got %h exp %h (steal_cnt 40, rdy 1)", obs, e);
      end
   endtask

   task automatic test_abort();
      logic [VW-1:0] e;
      logic [CW-1:0] cnt_before;
      bit            aec_low = 1'b0;
      cnt_before = m_cnt;
      for (int i = 0; i < 4; i++) begin
         phi_step(i < 2, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL abort step=%0d got %h exp %h", i, obs, e);
         end
         if (aec !== 1'b1) aec_low = 1'b1;
      end
      checks++;
      if (aec_low || steal_cnt !== cnt_before || ba !== 1'b0) begin
         errors++;
         $display("FAIL abort_summary got aec_low=%0d cnt=%0d ba=%b exp aec_low=0 cnt=%0d ba=0",
                  aec_low, steal_cnt, ba, cnt_before);
      end
   endtask

   task automatic test_same_edge();
      logic [VW-1:0] e;
      for (int i = 1; i <= WARN + 1; i++) begin
         phi_step(1'b1, 1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL same_edge step=%0d got %h exp %h", i, obs, e);
         end
         checks++;
         if (i <= WARN && (ba !== 1'b1 || dma_gnt !== 1'b0 || bus_sel !== 2'd0)) begin
            errors++;
            $display("FAIL same_edge_warn step=%0d got ba=%b gnt=%b sel=%0d exp ba=1 gnt=0 sel=0",
                     i, ba, dma_gnt, bus_sel);
         end else if (i > WARN && (bus_sel !== 2'd1 || aec !== 1'b0)) begin
            errors++;
            $display("FAIL same_edge_steal got sel=%0d aec=%b exp sel=1 aec=0", bus_sel, aec);
         end
      end
      phi_step(1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
   endtask

   task automatic test_dma_then_vic();
      logic [VW-1:0] e;
      for (int i = 0; i < 5; i++) begin
         phi_step(1'b0, 1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e || dma_gnt !== DMA_EN) begin
            errors++;
            $display("FAIL dma_own step=%0d got %h exp %h", i, obs, e);
         end
      end
      for (int i = 1; i <= WARN + 1; i++) begin
         phi_step(1'b1, 1'b1, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL dma_vic step=%0d got %h exp %h", i, obs, e);
         end
         checks++;
         if (i <= WARN && (dma_gnt !== DMA_EN || aec !== 1'b1)) begin
            errors++;
            $display("FAIL dma_vic_warn step=%0d got gnt=%b aec=%b exp gnt=%b aec=1",
                     i, dma_gnt, aec, DMA_EN);
         end else if (i > WARN && (dma_gnt !== 1'b0 || bus_sel !== 2'd1)) begin
            errors++;
            $display("FAIL dma_vic_steal got gnt=%b sel=%0d exp gnt=0 sel=1", dma_gnt, bus_sel);
         end
      end
      for (int i = 0; i < 2; i++) begin
         phi_step(1'b0, 1'b0, 1'b0);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_reset_mid_steal();
      logic [VW-1:0] e;
      for (int i = 0; i < WARN + 5; i++) begin
         phi_step(1'b1, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL pre_reset step=%0d got %h exp %h", i, obs, e);
         end
      end
      @(negedge dot_clk);
      #2;
      res_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (obs !== RESET_VEC) begin
         errors++;
         $display("FAIL async_reset_mid_steal got %h exp %h", obs, RESET_VEC);
      end
      vic_req = 1'b0;
      repeat (2) @(negedge dot_clk);
      res_n = 1'b1;
   endtask

   task automatic test_random();
      logic [VW-1:0] e;
      bit v = 1'b0;
      bit d = 1'b0;
      bit c;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0) v = ~v;
         if ($urandom_range(0, 3) == 0) d = ~d;
         c = ($urandom_range(0, 15) == 0);
         phi_step(v, d, c);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL random step=%0d v=%b d=%b c=%b got %h exp %h", i, v, d, c, obs, e);
         end
      end
      for (int i = 0; i < 2; i++) begin
         phi_step(1'b0, 1'b0, 1'b0);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_saturation();
      logic [VW-1:0] e;
      fast = 1'b1;
      phi_step(1'b0, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      for (int i = 0; i < 70000 && m_cnt != 16'hFFFD; i++) begin
         phi_step(1'b1, 1'b0, 1'b0);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL sat_ramp step=%0d got %h exp %h", i, obs, e);
         end
      end
      checks++;
      if (steal_cnt !== 16'hFFFD) begin
         errors++;
         $display("FAIL sat_near got %h exp fffd", steal_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         phi_step(1'b1, 1'b0, 1'b0);
         void'(exp_q.pop_front());
      end
      checks++;
      if (steal_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold got %h exp ffff", steal_cnt);
      end
      phi_step(1'b1, 1'b0, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (steal_cnt !== 16'h0000 || aec !== 1'b0) begin
         errors++;
         $display("FAIL clr_over_inc got cnt=%h aec=%b exp cnt=0000 aec=0", steal_cnt, aec);
      end
      phi_step(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (steal_cnt !== 16'h0001 || obs !== e) begin
         errors++;
         $display("FAIL inc_after_clr got %h exp %h", obs, e);
      end
      phi_step(1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      fast = 1'b0;
   endtask

   initial begin
      test_reset();
      test_long_steal();
      test_abort();
      test_same_edge();
      test_dma_then_vic();
      test_reset_mid_steal();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WARN_CYCLES, default 3: phi2 cycles between the BA warning and the VIC-II taking the bus.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stolen-cycle counter.
REQ-003 SHALL have port dot_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port res_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port phi_en, input, 1: one-dot_clk strobe marking the end of each phi2 cycle; state advances only when it is high.
REQ-006 SHALL have port vic_req, input, 1: VIC-II needs the bus for character/sprite fetches.
REQ-007 SHALL have port dma_req, input, 1: expansion-port DMA request, active high.
REQ-008 SHALL have port cnt_clr, input, 1: synchronous clear of steal_cnt.
REQ-009 SHALL have port ba, output, 1: high = steal pending or active, so the CPU must stop at its next read.
REQ-010 SHALL have port aec, output, 1: high = CPU or DMA drives the bus in phi2; low = VIC-II drives it.
REQ-011 SHALL have port rdy, output, 1: CPU ready; equals !ba & !dma_gnt.
REQ-012 SHALL have port dma_gnt, output, 1: expansion DMA owns the bus.
REQ-013 SHALL have port bus_sel, output, 2: bus owner; 0 = CPU, 1 = VIC, 2 = DMA, 3 = unused.
REQ-014 SHALL have port steal_cnt, output, CNT_W: count of stolen phi2 cycles.

Function
REQ-015 SHALL implement the states IDLE, WARN, STEAL and DMA; all transitions happen only on a dot_clk edge with phi_en=1.
REQ-016 SHALL go IDLE->WARN on vic_req=1, load the warn counter with WARN_CYCLES-1 and assert ba; VIC wins when vic_req and dma_req are both high.
REQ-017 SHALL go IDLE->DMA on dma_req=1 with vic_req=0, asserting dma_gnt and setting bus_sel=2.
REQ-018 SHALL in WARN decrement the counter each phi_en, keep aec=1 and keep the previous owner on bus_sel; go to STEAL when the counter is 0 and vic_req=1.
REQ-019 SHALL return WARN->IDLE and deassert ba if vic_req drops during WARN (abort, no cycle stolen).
REQ-020 SHALL in STEAL drive aec=0, ba=1, bus_sel=1 and dma_gnt=0; stay while vic_req=1; go to IDLE when vic_req=0.
REQ-021 SHALL in DMA go to WARN on vic_req=1 and keep dma_gnt high through WARN; go to IDLE on dma_req=0.
REQ-022 SHALL drive all outputs from registers, changing on the same edge as the state change.
REQ-023 SHALL increment steal_cnt by 1 per phi_en spent in STEAL and saturate at all-ones.
REQ-024 SHALL give cnt_clr priority over increment when both occur in the same cycle.

Reset
REQ-025 SHALL on res_n=0 immediately force IDLE, ba=0, aec=1, rdy=1, dma_gnt=0, bus_sel=0, steal_cnt=0 and the warn counter to 0, including mid-WARN or mid-STEAL.
REQ-026 SHALL take the first transition after res_n rises only at the next phi_en.

Configuration
REQ-027 SHALL with BUS_ARBITER_DMA_EN defined arbitrate dma_req as specified above.
REQ-028 SHALL with BUS_ARBITER_DMA_EN undefined ignore dma_req, omit the DMA state, hold dma_gnt=0 and never drive bus_sel=2.

Structure
REQ-029 SHALL place the state enum, the bus_sel encodings (SEL_CPU, SEL_VIC, SEL_DMA) and the WARN_CYCLES default constant in shared package c64_bus_pkg.
REQ-030 SHALL be a single module with no sub-module; the warn counter and steal counter are inline.

Verification
REQ-031 SHALL cover: vic_req=1 for 43 phi cycles from IDLE -> ba=1 for 3 phi cycles with aec=1, then aec=0 for 40 cycles, steal_cnt=40, then IDLE with rdy=1.
REQ-032 SHALL cover: vic_req pulse of 2 phi cycles -> WARN aborted, aec never 0, steal_cnt unchanged.
REQ-033 SHALL cover: vic_req and dma_req rising on the same phi_en -> WARN entered, dma_gnt=0, bus_sel=0 until STEAL, then bus_sel=1.
REQ-034 SHALL cover: dma_req held, then vic_req after 5 cycles -> dma_gnt stays 1 for 3 WARN cycles and drops on entry to STEAL.
REQ-035 SHALL cover: res_n=0 asserted mid-STEAL without a clock edge -> aec=1, ba=0, bus_sel=0, steal_cnt=0 immediately.
REQ-036 SHALL cover: steal_cnt preset near all-ones with vic_req held -> counter saturates at 0xFFFF; cnt_clr together with an increment -> 0.
